// File: rtl/dlx_dmem_bridge_pkg.sv
// Shared types and constants for the DLX data-memory load/store bridge.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    GAP  = 2'b10,
    WR   = 2'b11
  } bridge_state_t;

  // Size codes understood by the data memory; the bridge only ever issues word accesses.
  localparam logic [1:0] MEM_SZ_WORD = 2'b00;
  localparam logic [1:0] MEM_SZ_BYTE = 2'b01;
  localparam logic [1:0] MEM_SZ_HALF = 2'b10;

  localparam int TIMEOUT_DEFAULT = 16;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = offset[0];
      2'b10:   bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dlx_dmem_bridge_if.sv
// Request/response and word-memory signals between the DLX memory stage and data memory.
interface dlx_dmem_bridge_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int WORD_SIZE    = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    rsp_valid;
  logic [WORD_SIZE-1:0]    rsp_rdata;
  logic                    rsp_err;
  logic                    mem_enable;
  logic                    mem_rnw;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0]    mem_wdata;
  logic                    mem_wdata_oe;
  logic [WORD_SIZE-1:0]    mem_rdata;
  logic                    mem_ready;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_enable, mem_rnw, mem_address, mem_wdata, mem_wdata_oe,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_enable, mem_rnw, mem_address, mem_wdata, mem_wdata_oe,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/dlx_dmem_bridge_mem_lane_align.sv
// Big-endian byte/half lane extraction with extension, and lane merge for read-modify-write.
module mem_lane_align
  import dlx_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] wr_word
);

  logic [4:0]  lsb_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Offset 0 is the most significant lane, so the byte lane LSB is (3-offset)*8.
  always_comb begin
    lsb_s   = {~offset, 3'b000};
    byte_s  = word[lsb_s +: 8];
    half_s  = offset[1] ? word[15:0] : word[31:16];
    ld_data = 32'd0;
    wr_word = word;
    case (size)
      BYTE: begin
        ld_data              = {{24{sign_ext & byte_s[7]}}, byte_s};
        wr_word[lsb_s +: 8]  = wdata[7:0];
      end
      HALF: begin
        ld_data = {{16{sign_ext & half_s[15]}}, half_s};
        if (offset[1]) begin
          wr_word[15:0] = wdata[15:0];
        end else begin
          wr_word[31:16] = wdata[15:0];
        end
      end
      WORD: begin
        ld_data = word;
        wr_word = wdata;
      end
      default: begin
        ld_data = 32'd0;
        wr_word = word;
      end
    endcase
  end

endmodule

// File: rtl/dlx_dmem_bridge.sv
// Load/store bridge: alignment checks, word-granular memory accesses, RMW for sub-word
// stores, timeout abort and a single-cycle response.
module dlx_dmem_bridge
  import dlx_mem_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int ADDRESS_SIZE   = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic rst,
  dlx_dmem_bridge_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t           state_r;
  logic                    we_r;
  size_t                   size_r;
  logic                    sign_r;
  logic [1:0]              off_r;
  logic [WORD_SIZE-1:0]    wdata_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    err_pend_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [WORD_SIZE-1:0]    rsp_rdata_r;
  logic                    mem_enable_r;
  logic                    mem_rnw_r;
  logic [ADDRESS_SIZE-1:0] mem_address_r;
  logic [WORD_SIZE-1:0]    mem_wdata_r;
  logic                    mem_wdata_oe_r;

  logic                    req_err_s;
  logic                    access_done_s;
  logic                    access_tmo_s;
  logic [WORD_SIZE-1:0]    ld_data_s;
  logic [WORD_SIZE-1:0]    wr_word_s;

  assign req_err_s     = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  // DATA_READY may still be high from the previous access, so it is ignored on the first edge.
  assign access_done_s = (cnt_r != {CNT_W{1'b0}}) && bus.mem_ready;
  assign access_tmo_s  = !access_done_s && (cnt_r == CNT_LAST);

  assign bus.req_ready    = (state_r == IDLE) && rst;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_err      = rsp_err_r;
  assign bus.rsp_rdata    = rsp_rdata_r;
  assign bus.mem_enable   = mem_enable_r;
  assign bus.mem_rnw      = mem_rnw_r;
  assign bus.mem_address  = mem_address_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign bus.mem_wdata_oe = mem_wdata_oe_r;

  mem_lane_align u_lane (
    .word     (bus.mem_rdata),
    .offset   (off_r),
    .size     (size_r),
    .sign_ext (sign_r),
    .wdata    (wdata_r),
    .ld_data  (ld_data_s),
    .wr_word  (wr_word_s)
  );

  // Bridge FSM with all memory and response outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      we_r           <= 1'b0;
      size_r         <= BYTE;
      sign_r         <= 1'b0;
      off_r          <= 2'b00;
      wdata_r        <= '0;
      cnt_r          <= {CNT_W{1'b0}};
      err_pend_r     <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_err_r      <= 1'b0;
      rsp_rdata_r    <= '0;
      mem_enable_r   <= 1'b0;
      mem_rnw_r      <= 1'b0;
      mem_address_r  <= '0;
      mem_wdata_r    <= '0;
      mem_wdata_oe_r <= 1'b0;
    end else begin
      rsp_valid_r <= err_pend_r;
      rsp_err_r   <= err_pend_r;
      rsp_rdata_r <= '0;
      err_pend_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r    <= bus.req_we;
            size_r  <= size_t'(bus.req_size);
            sign_r  <= bus.req_signed;
            off_r   <= bus.req_addr[1:0];
            wdata_r <= bus.req_wdata;
            cnt_r   <= {CNT_W{1'b0}};
            if (req_err_s) begin
              err_pend_r <= 1'b1;
            end else if (!bus.req_we || (bus.req_size != WORD)) begin
              state_r       <= RD;
              mem_enable_r  <= 1'b1;
              mem_rnw_r     <= 1'b1;
              mem_address_r <= {bus.req_addr[ADDRESS_SIZE-1:2], 2'b00};
            end else begin
              state_r        <= WR;
              mem_enable_r   <= 1'b1;
              mem_rnw_r      <= 1'b0;
              mem_wdata_oe_r <= 1'b1;
              mem_wdata_r    <= bus.req_wdata;
              mem_address_r  <= {bus.req_addr[ADDRESS_SIZE-1:2], 2'b00};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          if (access_done_s) begin
            mem_enable_r <= 1'b0;
            mem_rnw_r    <= 1'b0;
            if (!we_r) begin
              state_r     <= IDLE;
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= ld_data_s;
            end else begin
              state_r     <= GAP;
              mem_wdata_r <= wr_word_s;
            end
          end else if (access_tmo_s) begin
            state_r      <= IDLE;
            mem_enable_r <= 1'b0;
            mem_rnw_r    <= 1'b0;
            rsp_valid_r  <= 1'b1;
            rsp_err_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        GAP: begin
          state_r        <= WR;
          mem_enable_r   <= 1'b1;
          mem_rnw_r      <= 1'b0;
          mem_wdata_oe_r <= 1'b1;
          cnt_r          <= {CNT_W{1'b0}};
        end
        WR: begin
          if (access_done_s || access_tmo_s) begin
            state_r        <= IDLE;
            mem_enable_r   <= 1'b0;
            mem_wdata_oe_r <= 1'b0;
            mem_wdata_r    <= '0;
            rsp_valid_r    <= 1'b1;
            rsp_err_r      <= access_tmo_s;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r        <= IDLE;
          mem_enable_r   <= 1'b0;
          mem_wdata_oe_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_dmem_bridge.sv
// Scoreboard bench for dlx_dmem_bridge against a word memory whose DATA_READY stays high.
module tb_dlx_dmem_bridge;

  logic clk;
  logic rst;
  logic init_n;
  logic stall;
  int   cyc;
  int   n_total;
  int   n_bad;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mem [256];
  int          wr_age;
  logic [63:0] en_h;
  logic [63:0] rnw_h;
  logic [63:0] oe_h;
  logic [63:0] rr_h;
  logic [31:0] wd_h [64];
  logic [31:0] ad_h [64];

  dlx_dmem_bridge_if #(.ADDRESS_SIZE(32), .WORD_SIZE(32)) bus ();

  dlx_dmem_bridge #(
    .WORD_SIZE      (32),
    .ADDRESS_SIZE   (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_address[9:2]];
  assign bus.mem_ready = !stall;

  // Word memory: a write commits only once the access has lasted at least one edge.
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[64] <= 32'h8899AABB;
      wr_age  <= 0;
    end else if (bus.mem_enable && !bus.mem_rnw) begin
      if (bus.mem_wdata_oe && bus.mem_ready && wr_age != 0)
        mem[bus.mem_address[9:2]] <= bus.mem_wdata;
      wr_age <= wr_age + 1;
    end else begin
      wr_age <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard and checks data, error and latency.
  always @(negedge clk) begin
    if (rst && bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    int   k;
    bit   done;
    en_h = '0; rnw_h = '0; oe_h = '0; rr_h = '0;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    e.rdata = er; e.err = ee; e.lat = lat; e.acc = cyc;
    sbq.push_back(e);
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en_h[i]  = bus.mem_enable;
      rnw_h[i] = bus.mem_rnw;
      oe_h[i]  = bus.mem_wdata_oe;
      rr_h[i]  = bus.req_ready;
      wd_h[i]  = bus.mem_wdata;
      ad_h[i]  = bus.mem_address;
      #1;
      if (sbq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  initial begin
    int k;
    n_total = 0; n_bad = 0; cyc = 0; stall = 1'b0;
    rst = 1'b0; init_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #12 init_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {29'd0, bus.req_ready, bus.mem_enable, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_outputs", {bus.mem_address[29:0], bus.mem_enable, bus.mem_wdata_oe}, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'h8899AABB, 1'b0, 2);
    chk("lw_trace_en", {29'd0, en_h[2:0]}, 32'd3);
    chk("lw_trace_rnw", {30'd0, rnw_h[1:0]}, 32'd3);
    chk("lw_address", ad_h[0], 32'h100);

    do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 32'hFFFFFF99, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h000000BB, 1'b0, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h100, 32'd0, 32'hFFFFFF88, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 32'hFFFFAABB, 1'b0, 2);
    do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'd0, 32'h00008899, 1'b0, 2);

    do_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h00000011, 32'd0, 1'b0, 5);
    chk("sb_trace_en", {26'd0, en_h[5:0]}, 32'h1B);
    chk("sb_write_phase", {29'd0, rnw_h[3], oe_h[3], oe_h[1]}, 32'd2);
    chk("sb_write_data", wd_h[3], 32'h889911BB);
    chk("sb_write_addr", ad_h[3], 32'h100);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'h889911BB, 1'b0, 2);

    do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    chk("sw_trace", {28'd0, oe_h[1:0], en_h[1:0]}, 32'hF);
    do_req(1'b1, 2'b01, 1'b0, 32'h106, 32'h0000CAFE, 32'd0, 1'b0, 5);
    do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 32'hDEADCAFE, 1'b0, 2);

    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'd0, 32'd0, 1'b1, 1);
    chk("lh_misaligned_no_access", {30'd0, en_h[1:0]}, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 32'd0, 1'b1, 1);
    chk("sw_misaligned_no_access", {30'd0, en_h[1:0]}, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1, 1);
    chk("mem_after_errors", mem[64], 32'h889911BB);

    stall = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'd0, 1'b1, 16);
    chk("tmo_enable_edge", {30'd0, en_h[15], en_h[16]}, 32'd2);
    chk("tmo_ready_after", {31'd0, rr_h[16]}, 32'd1);
    stall = 1'b0;

    // Reset asserted in the write phase of a sub-word store.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h102; bus.req_wdata = 32'h00000022;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.mem_enable && !bus.mem_rnw) && k < 20);
    chk("reached_wr_phase", {31'd0, bus.mem_wdata_oe}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_outputs", {bus.mem_address[28:0], bus.mem_enable, bus.mem_rnw, bus.mem_wdata_oe}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rsp_outputs", {29'd0, bus.rsp_valid, bus.rsp_err, bus.req_ready}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_release", {31'd0, bus.req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("mem_unchanged_by_reset", mem[64], 32'h889911BB);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'h889911BB, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
